// File: rtl/fpu_sub_seq.sv
`default_nettype none
// ============================================================================
// Module   : fpu_sub_seq
// Brief    : Multi-cycle binary16 subtractor (a - b) with a valid/ready handshake.
//            Define FPU_SUB_SUBNORM_EN for exact subnormals; otherwise subnormals flush to zero.
// Revision : 1.0 - initial release
// ============================================================================
module fpu_sub_seq (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] out_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_nan
);

    localparam logic [2:0]  S_IDLE   = 3'd0;
    localparam logic [2:0]  S_UNPACK = 3'd1;
    localparam logic [2:0]  S_ALIGN  = 3'd2;
    localparam logic [2:0]  S_ADD    = 3'd3;
    localparam logic [2:0]  S_NORM   = 3'd4;
    localparam logic [2:0]  S_PACK   = 3'd5;
    localparam logic [2:0]  S_DONE   = 3'd6;

    localparam logic [4:0]  C_EXP_MAX   = 5'h1f;
    localparam logic [4:0]  C_MAX_SHIFT = 5'd14;
    localparam logic [15:0] C_QNAN      = 16'h7E00;

    logic [2:0]  state_q, state_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic        sign_q, sign_d;
    logic        sub_q, sub_d;
    logic [5:0]  exp_q, exp_d;
    logic [14:0] sig_l_q, sig_l_d;
    logic [13:0] sig_s_q, sig_s_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] result_q, result_d;
    logic        nan_q, nan_d;

    logic        w_b_sign;
    logic        w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
    logic        w_special, w_special_nan;
    logic [15:0] w_special_res;
    logic        w_a_ge_b;
    logic [4:0]  w_ea_eff, w_eb_eff, w_exp_diff;
    logic [13:0] w_sig_a, w_sig_b;
    logic        w_norm_done;
    logic [15:0] w_pack_res;

    // Operand classification and special-case results for UNPACK
    always_comb begin
        w_b_sign = ~b_q[15];
        w_a_nan  = (a_q[14:10] == C_EXP_MAX) && (a_q[9:0] != 10'd0);
        w_b_nan  = (b_q[14:10] == C_EXP_MAX) && (b_q[9:0] != 10'd0);
        w_a_inf  = (a_q[14:10] == C_EXP_MAX) && (a_q[9:0] == 10'd0);
        w_b_inf  = (b_q[14:10] == C_EXP_MAX) && (b_q[9:0] == 10'd0);
`ifdef FPU_SUB_SUBNORM_EN
        w_a_zero = (a_q[14:0] == 15'd0);
        w_b_zero = (b_q[14:0] == 15'd0);
`else
        w_a_zero = (a_q[14:10] == 5'd0);
        w_b_zero = (b_q[14:10] == 5'd0);
`endif
        w_special     = 1'b1;
        w_special_nan = 1'b0;
        w_special_res = 16'h0000;
        if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (a_q[15] == b_q[15]))) begin
            w_special_res = C_QNAN;
            w_special_nan = 1'b1;
        end else if (w_a_inf) begin
            w_special_res = a_q;
        end else if (w_b_inf) begin
            w_special_res = {w_b_sign, b_q[14:0]};
        end else if (w_a_zero && w_b_zero) begin
            w_special_res = 16'h0000;
        end else if (w_a_zero) begin
            w_special_res = {w_b_sign, b_q[14:0]};
        end else if (w_b_zero) begin
            w_special_res = a_q;
        end else begin
            w_special = 1'b0;
        end

        w_ea_eff   = (a_q[14:10] == 5'd0) ? 5'd1 : a_q[14:10];
        w_eb_eff   = (b_q[14:10] == 5'd0) ? 5'd1 : b_q[14:10];
        w_sig_a    = {|a_q[14:10], a_q[9:0], 3'b000};
        w_sig_b    = {|b_q[14:10], b_q[9:0], 3'b000};
        w_a_ge_b   = (a_q[14:0] >= b_q[14:0]);
        w_exp_diff = w_a_ge_b ? (w_ea_eff - w_eb_eff) : (w_eb_eff - w_ea_eff);
    end

    // Normalisation stop condition and final encoding
    always_comb begin
        w_norm_done = sig_l_q[14] | sig_l_q[13] | (sig_l_q == 15'd0) | (exp_q == 6'd1);
        if (sig_l_q == 15'd0) begin
            w_pack_res = 16'h0000;
        end else if (exp_q >= 6'd31) begin
            w_pack_res = {sign_q, C_EXP_MAX, 10'd0};
        end else if (!sig_l_q[13]) begin
`ifdef FPU_SUB_SUBNORM_EN
            w_pack_res = {sign_q, 5'd0, sig_l_q[12:3]};
`else
            w_pack_res = 16'h0000;
`endif
        end else begin
            w_pack_res = {sign_q, exp_q[4:0], sig_l_q[12:3]};
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (in_valid) state_d = S_UNPACK;
            S_UNPACK: begin
                if (w_special)                state_d = S_DONE;
                else if (w_exp_diff != 5'd0)  state_d = S_ALIGN;
                else                          state_d = S_ADD;
            end
            S_ALIGN:  if (cnt_q == 4'd1) state_d = S_ADD;
            S_ADD:    state_d = S_NORM;
            S_NORM:   if (w_norm_done) state_d = S_PACK;
            S_PACK:   state_d = S_DONE;
            S_DONE:   if (out_ready) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready   = (state_q == S_IDLE);
        out_valid  = (state_q == S_DONE);
        out_result = result_q;
        out_nan    = nan_q & (state_q == S_DONE);
    end

    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        sign_d   = sign_q;
        sub_d    = sub_q;
        exp_d    = exp_q;
        sig_l_d  = sig_l_q;
        sig_s_d  = sig_s_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        nan_d    = nan_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d = in_a;
                    b_d = in_b;
                end
            end
            S_UNPACK: begin
                result_d = w_special_res;
                nan_d    = w_special_nan;
                sub_d    = a_q[15] ^ w_b_sign;
                if (w_a_ge_b) begin
                    sign_d  = a_q[15];
                    exp_d   = {1'b0, w_ea_eff};
                    sig_l_d = {1'b0, w_sig_a};
                    sig_s_d = w_sig_b;
                end else begin
                    sign_d  = w_b_sign;
                    exp_d   = {1'b0, w_eb_eff};
                    sig_l_d = {1'b0, w_sig_b};
                    sig_s_d = w_sig_a;
                end
                // Beyond 14 shifts the smaller significand is entirely gone
                cnt_d = (w_exp_diff > C_MAX_SHIFT) ? C_MAX_SHIFT[3:0] : w_exp_diff[3:0];
            end
            S_ALIGN: begin
                sig_s_d = sig_s_q >> 1;
                cnt_d   = cnt_q - 4'd1;
            end
            S_ADD: begin
                sig_l_d = sub_q ? (sig_l_q - {1'b0, sig_s_q}) : (sig_l_q + {1'b0, sig_s_q});
            end
            S_NORM: begin
                if (sig_l_q[14]) begin
                    sig_l_d = sig_l_q >> 1;
                    exp_d   = exp_q + 6'd1;
                end else if (!w_norm_done) begin
                    sig_l_d = sig_l_q << 1;
                    exp_d   = exp_q - 6'd1;
                end
            end
            S_PACK: begin
                result_d = w_pack_res;
                nan_d    = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            a_q      <= 16'h0000;
            b_q      <= 16'h0000;
            sign_q   <= 1'b0;
            sub_q    <= 1'b0;
            exp_q    <= 6'd0;
            sig_l_q  <= 15'd0;
            sig_s_q  <= 14'd0;
            cnt_q    <= 4'd0;
            result_q <= 16'h0000;
            nan_q    <= 1'b0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            sign_q   <= sign_d;
            sub_q    <= sub_d;
            exp_q    <= exp_d;
            sig_l_q  <= sig_l_d;
            sig_s_q  <= sig_s_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            nan_q    <= nan_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fpu_sub_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpu_sub_seq
// Brief    : Self-checking bench for fpu_sub_seq against an integer-arithmetic reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fpu_sub_seq;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] in_a = 16'h0000;
    logic [15:0] in_b = 16'h0000;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] out_result;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_nan;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    fpu_sub_seq dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_result (out_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_nan    (out_nan)
    );

    // Reference: a - b evaluated with the block's arithmetic rules on plain integers
    function automatic void ref_sub(input logic [15:0] a, input logic [15:0] b,
                                    output logic [15:0] r, output logic n, output logic sp);
        int  ea, eb, fa, fb, el, es, sl, ss, d, rr, e;
        logic sa, sbe, za, zb, sign;
        sa  = a[15];
        sbe = ~b[15];
        ea  = int'(a[14:10]);
        eb  = int'(b[14:10]);
        fa  = int'(a[9:0]);
        fb  = int'(b[9:0]);
        r   = 16'h0000;
        n   = 1'b0;
        sp  = 1'b1;
        if ((ea == 31 && fa != 0) || (eb == 31 && fb != 0) || (ea == 31 && eb == 31 && a[15] == b[15])) begin
            r = 16'h7E00;
            n = 1'b1;
            return;
        end
        if (ea == 31) begin r = a; return; end
        if (eb == 31) begin r = {sbe, b[14:0]}; return; end
`ifdef FPU_SUB_SUBNORM_EN
        za = (ea == 0 && fa == 0);
        zb = (eb == 0 && fb == 0);
`else
        za = (ea == 0);
        zb = (eb == 0);
`endif
        if (za && zb) begin r = 16'h0000; return; end
        if (za) begin r = {sbe, b[14:0]}; return; end
        if (zb) begin r = a; return; end
        sp = 1'b0;
        if (ea * 1024 + fa >= eb * 1024 + fb) begin
            sign = sa;
            el = (ea == 0) ? 1 : ea;  es = (eb == 0) ? 1 : eb;
            sl = ((ea != 0) ? 1024 : 0) + fa;  ss = ((eb != 0) ? 1024 : 0) + fb;
        end else begin
            sign = sbe;
            el = (eb == 0) ? 1 : eb;  es = (ea == 0) ? 1 : ea;
            sl = ((eb != 0) ? 1024 : 0) + fb;  ss = ((ea != 0) ? 1024 : 0) + fa;
        end
        sl = sl * 8;
        ss = ss * 8;
        d  = el - es;
        if (d > 14) d = 14;
        ss = ss >> d;
        rr = (sa == sbe) ? sl + ss : sl - ss;
        e  = el;
        if (rr == 0) begin r = 16'h0000; return; end
        if (rr >= 16384) begin
            rr = rr / 2;
            e  = e + 1;
        end else begin
            while (rr < 8192 && e > 1) begin
                rr = rr * 2;
                e  = e - 1;
            end
        end
        if (e >= 31) r = {sign, 5'h1f, 10'h000};
        else if (rr < 8192) begin
`ifdef FPU_SUB_SUBNORM_EN
            r = {sign, 5'd0, 10'(rr / 8)};
`else
            r = 16'h0000;
`endif
        end else r = {sign, 5'(e), 10'((rr / 8) % 1024)};
    endfunction

    function automatic logic [15:0] rand_operand();
        logic [15:0] v;
        v = 16'($urandom);
        case ($urandom_range(0, 9))
            0: v[14:0] = 15'd0;
            1: v[14:0] = {5'h1f, 10'd0};
            2: v[14:10] = 5'h1f;
            3: v[14:10] = 5'd0;
            default: v[14:10] = 5'($urandom_range(1, 30));
        endcase
        return v;
    endfunction

    // Runs one transaction; scrambles inputs and in_valid while busy
    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input bit early_rdy,
                         output logic [15:0] res, output logic nan, output int lat, output bit to);
        int guard;
        to    = 1'b0;
        lat   = 0;
        res   = 16'h0000;
        nan   = 1'b0;
        guard = 0;
        @(negedge clock);
        while (!in_ready && guard < 50) begin
            @(negedge clock);
            guard++;
        end
        if (!in_ready) begin
            to = 1'b1;
            return;
        end
        in_a      = a;
        in_b      = b;
        in_valid  = 1'b1;
        out_ready = early_rdy;
        while (1'b1) begin
            @(negedge clock);
            lat++;
            if (out_valid) break;
            if (lat > 40) begin
                to       = 1'b1;
                in_valid = 1'b0;
                return;
            end
            in_valid = 1'($urandom_range(0, 1));
            in_a     = 16'($urandom);
            in_b     = 16'($urandom);
        end
        in_valid  = 1'b0;
        res       = out_result;
        nan       = out_nan;
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        n_checks++;
        if ({in_ready, out_valid, out_nan, out_result} !== {1'b1, 1'b0, 1'b0, 16'h0000}) begin
            n_errors++;
            $display("FAIL reset_state: got rdy=%b vld=%b nan=%b res=%h, expected rdy=1 vld=0 nan=0 res=0000",
                     in_ready, out_valid, out_nan, out_result);
        end
    endtask

    task automatic test_directed();
        logic [15:0] va [12];
        logic [15:0] vb [12];
        logic [15:0] vr [12];
        logic        vn [12];
        logic        vs [12];
        logic [15:0] res;
        logic        nan;
        int          lat;
        bit          to;
        va = '{16'h4200, 16'h3C00, 16'h3C00, 16'h7C00, 16'h7BFF, 16'h0400,
               16'h7C00, 16'h0000, 16'h8000, 16'h7E00, 16'h7000, 16'h3C00};
        vb = '{16'h3C00, 16'h3C00, 16'hBC00, 16'h7C00, 16'hFBFF, 16'h0200,
               16'hFC00, 16'h3C00, 16'h8000, 16'h3C00, 16'h1000, 16'h3BFF};
`ifdef FPU_SUB_SUBNORM_EN
        vr = '{16'h4000, 16'h0000, 16'h4000, 16'h7E00, 16'h7C00, 16'h0200,
               16'h7C00, 16'hBC00, 16'h0000, 16'h7E00, 16'h7000, 16'h1000};
`else
        vr = '{16'h4000, 16'h0000, 16'h4000, 16'h7E00, 16'h7C00, 16'h0400,
               16'h7C00, 16'hBC00, 16'h0000, 16'h7E00, 16'h7000, 16'h1000};
`endif
        vn = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vs = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
`ifndef FPU_SUB_SUBNORM_EN
        vs[5] = 1'b1;
`endif
        for (int i = 0; i < 12; i++) begin
            do_op(va[i], vb[i], 1'b0, res, nan, lat, to);
            n_checks++;
            if (to || res !== vr[i] || nan !== vn[i]) begin
                n_errors++;
                $display("FAIL directed_%0d: %h-%h got res=%h nan=%b timeout=%b, expected res=%h nan=%b",
                         i, va[i], vb[i], res, nan, to, vr[i], vn[i]);
            end
            n_checks++;
            if (vs[i] ? (lat != 2) : (lat > 29)) begin
                n_errors++;
                $display("FAIL directed_latency_%0d: got %0d cycles, expected %s", i, lat,
                         vs[i] ? "2" : "<=29");
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] a, b, res, er;
        logic        nan, en, sp;
        int          lat;
        bit          to;
        for (int i = 0; i < 300; i++) begin
            a = rand_operand();
            b = rand_operand();
            if ($urandom_range(0, 3) == 0) begin
                b = a ^ 16'($urandom_range(0, 7));
                if ($urandom_range(0, 1) == 1) b[14:10] = a[14:10] - 5'd1;
            end
            ref_sub(a, b, er, en, sp);
            do_op(a, b, 1'($urandom_range(0, 1)), res, nan, lat, to);
            n_checks++;
            if (to || res !== er || nan !== en) begin
                n_errors++;
                $display("FAIL random_%0d: %h-%h got res=%h nan=%b timeout=%b, expected res=%h nan=%b",
                         i, a, b, res, nan, to, er, en);
            end
            n_checks++;
            if (sp ? (lat != 2) : (lat > 29)) begin
                n_errors++;
                $display("FAIL random_latency_%0d: %h-%h got %0d cycles, expected %s",
                         i, a, b, lat, sp ? "2" : "<=29");
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] a, b, res, er;
        logic        nan, en, sp;
        int          lat;
        bit          to;
        for (int i = 0; i < 20; i++) begin
            a = {1'($urandom), 5'($urandom_range(1, 30)), 10'($urandom)};
            b = {1'($urandom), 5'($urandom_range(1, 30)), 10'($urandom)};
            ref_sub(a, b, er, en, sp);
            do_op(a, b, 1'b1, res, nan, lat, to);
            n_checks++;
            if (to || res !== er || nan !== en) begin
                n_errors++;
                $display("FAIL back_to_back_%0d: %h-%h got res=%h nan=%b, expected res=%h nan=%b",
                         i, a, b, res, nan, er, en);
            end
        end
    endtask

    task automatic test_hold_and_abort();
        int   guard;
        bit   seen;
        logic [15:0] res;
        logic nan;
        int   lat;
        bit   to;
        @(negedge clock);
        in_a = 16'h4200;
        in_b = 16'h3C00;
        in_valid = 1'b1;
        out_ready = 1'b0;
        @(negedge clock);
        in_valid = 1'b0;
        guard = 0;
        while (!out_valid && guard < 40) begin
            @(negedge clock);
            guard++;
        end
        n_checks++;
        if (!out_valid) begin
            n_errors++;
            $display("FAIL hold_wait: out_valid=%b after %0d cycles, expected 1", out_valid, guard);
        end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if ({out_valid, in_ready, out_result} !== {1'b1, 1'b0, 16'h4000}) begin
                n_errors++;
                $display("FAIL hold_%0d: got vld=%b rdy=%b res=%h, expected vld=1 rdy=0 res=4000",
                         i, out_valid, in_ready, out_result);
            end
            @(negedge clock);
        end
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        // Second operation with a large exponent gap, reset while aligning
        in_a = 16'h7000;
        in_b = 16'h1000;
        in_valid = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        repeat (3) @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        n_checks++;
        if ({out_valid, in_ready, out_nan, out_result} !== {1'b0, 1'b1, 1'b0, 16'h0000}) begin
            n_errors++;
            $display("FAIL abort_state: got vld=%b rdy=%b nan=%b res=%h, expected vld=0 rdy=1 nan=0 res=0000",
                     out_valid, in_ready, out_nan, out_result);
        end
        seen = 1'b0;
        for (int i = 0; i < 35; i++) begin
            @(negedge clock);
            if (out_valid) seen = 1'b1;
        end
        n_checks++;
        if (seen) begin
            n_errors++;
            $display("FAIL abort_no_output: got out_valid=1 after reset, expected 0");
        end
        do_op(16'h3C00, 16'hBC00, 1'b0, res, nan, lat, to);
        n_checks++;
        if (to || res !== 16'h4000 || nan !== 1'b0) begin
            n_errors++;
            $display("FAIL post_abort_op: got res=%h nan=%b timeout=%b, expected res=4000 nan=0",
                     res, nan, to);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_hold_and_abort();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
